// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the main control FSM and the PC sequencer.
// The master side is the control unit. It raises one-cycle redirect and exception
// requests and watches the PC-mux selector, the write strobes and the busy flag.
// The slave side is the sequencer itself.
interface pc_sequencer_if;
  logic       fetch_req;
  logic       br_req;
  logic       br_taken;
  logic       j_req;
  logic       jr_req;
  logic       rte_req;
  logic       exc_req;
  logic [1:0] exc_code;
  logic [2:0] pc_sel;
  logic       pc_write;
  logic       epc_write;
  logic       alu_pc_m4;
  logic [7:0] vec_addr;
  logic       vec_addr_en;
  logic [1:0] cause;
  logic       busy;

  modport master (
    output fetch_req, br_req, br_taken, j_req, jr_req, rte_req, exc_req, exc_code,
    input  pc_sel, pc_write, epc_write, alu_pc_m4, vec_addr, vec_addr_en, cause, busy
  );

  modport slave (
    input  fetch_req, br_req, br_taken, j_req, jr_req, rte_req, exc_req, exc_code,
    output pc_sel, pc_write, epc_write, alu_pc_m4, vec_addr, vec_addr_en, cause, busy
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC source sequencer for the multicycle MIPS datapath.
// In IDLE it turns one-cycle redirect requests into a registered PC-mux selector
// and a single-cycle PC write pulse. It also walks the exception entry:
// save EPC (PC-4), hold the vector address while memory settles, then load the PC
// from the handler byte. Every output comes straight from a flop.
module pc_sequencer #(
  parameter int         MEM_WAIT = 2,
  parameter logic [7:0] VEC_BASE = 8'd253
) (
  input logic           clk_i,
  input logic           rst_i,
  pc_sequencer_if.slave bus
);

  localparam int              CntW    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_WAIT - 1);

  localparam logic [2:0] SelLoad  = 3'b000;
  localparam logic [2:0] SelAlu   = 3'b001;
  localparam logic [2:0] SelAluOut = 3'b010;
  localparam logic [2:0] SelJump  = 3'b011;
  localparam logic [2:0] SelEpc   = 3'b100;
  localparam logic [2:0] SelRegA  = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXC_EPC  = 2'd1,
    EXC_MEM  = 2'd2,
    EXC_LOAD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      pcSel_q, pcSel_d;
  logic            pcWrite_q, pcWrite_d;
  logic            epcWrite_q, epcWrite_d;
  logic            aluPcM4_q, aluPcM4_d;
  logic [7:0]      vecAddr_q, vecAddr_d;
  logic            vecAddrEn_q, vecAddrEn_d;
  logic [1:0]      cause_q, cause_d;
  logic            busy_q, busy_d;
  logic [1:0]      excCause;

  // Reserved code 3 has no handler of its own; it shares the invalid-opcode vector.
  assign excCause = (bus.exc_code == 2'd3) ? 2'd0 : bus.exc_code;

  // Next state and next registered outputs. Every output is computed for the cycle
  // that follows the edge, so the control unit sees the strobes without a comb path.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcSel_d     = pcSel_q;
    pcWrite_d   = 1'b0;
    epcWrite_d  = 1'b0;
    aluPcM4_d   = 1'b0;
    vecAddr_d   = vecAddr_q;
    vecAddrEn_d = 1'b0;
    cause_d     = cause_q;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.exc_req) begin
          cause_d    = excCause;
          vecAddr_d  = VEC_BASE + {6'b000000, excCause};
          state_d    = EXC_EPC;
          epcWrite_d = 1'b1;
          aluPcM4_d  = 1'b1;
          busy_d     = 1'b1;
        end else if (bus.rte_req) begin
          pcSel_d   = SelEpc;
          pcWrite_d = 1'b1;
        end else if (bus.jr_req) begin
          pcSel_d   = SelRegA;
          pcWrite_d = 1'b1;
        end else if (bus.j_req) begin
          pcSel_d   = SelJump;
          pcWrite_d = 1'b1;
        end else if (bus.br_req && bus.br_taken) begin
          pcSel_d   = SelAluOut;
          pcWrite_d = 1'b1;
        end else if (bus.fetch_req) begin
          pcSel_d   = SelAlu;
          pcWrite_d = 1'b1;
        end
      end

      EXC_EPC: begin
        state_d     = EXC_MEM;
        cnt_d       = CntLoad;
        vecAddrEn_d = 1'b1;
        busy_d      = 1'b1;
      end

      EXC_MEM: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d   = EXC_LOAD;
          pcSel_d   = SelLoad;
          pcWrite_d = 1'b1;
        end else begin
          cnt_d       = cnt_q - CntW'(1);
          vecAddrEn_d = 1'b1;
        end
      end

      EXC_LOAD: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears a half-done exception entry at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pcSel_q     <= 3'b000;
      pcWrite_q   <= 1'b0;
      epcWrite_q  <= 1'b0;
      aluPcM4_q   <= 1'b0;
      vecAddr_q   <= 8'd0;
      vecAddrEn_q <= 1'b0;
      cause_q     <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pcSel_q     <= pcSel_d;
      pcWrite_q   <= pcWrite_d;
      epcWrite_q  <= epcWrite_d;
      aluPcM4_q   <= aluPcM4_d;
      vecAddr_q   <= vecAddr_d;
      vecAddrEn_q <= vecAddrEn_d;
      cause_q     <= cause_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.pc_sel      = pcSel_q;
  assign bus.pc_write    = pcWrite_q;
  assign bus.epc_write   = epcWrite_q;
  assign bus.alu_pc_m4   = aluPcM4_q;
  assign bus.vec_addr    = vecAddr_q;
  assign bus.vec_addr_en = vecAddrEn_q;
  assign bus.cause       = cause_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed steps followed by random request traffic.
// A reference model predicts every output cycle. It works from the request
// priority list and a queue of the cycles that an exception entry will produce.
module tb_pc_sequencer;

  localparam int         MemWait = 2;
  localparam logic [7:0] VecBase = 8'd253;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(.MEM_WAIT(MemWait), .VEC_BASE(VecBase)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] pcSel;
    logic       pcWrite;
    logic       epcWrite;
    logic       aluPcM4;
    logic [7:0] vecAddr;
    logic       vecAddrEn;
    logic [1:0] cause;
    logic       busy;
  } outs_t;

  outs_t      expQ[$];
  outs_t      expOut;
  outs_t      zeroOut;
  logic [2:0] lastSel;
  logic [1:0] lastCause;
  logic [7:0] lastVec;
  int         testsRun = 0;
  int         testsFailed = 0;

  function automatic outs_t observed();
    outs_t o;
    o.pcSel     = bus.pc_sel;
    o.pcWrite   = bus.pc_write;
    o.epcWrite  = bus.epc_write;
    o.aluPcM4   = bus.alu_pc_m4;
    o.vecAddr   = bus.vec_addr;
    o.vecAddrEn = bus.vec_addr_en;
    o.cause     = bus.cause;
    o.busy      = bus.busy;
    return o;
  endfunction

  function automatic outs_t idleRecord();
    outs_t o;
    o           = '0;
    o.pcSel     = lastSel;
    o.vecAddr   = lastVec;
    o.cause     = lastCause;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input outs_t want);
    outs_t got;
    got = observed();
    testsRun++;
    assert (got === want) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed sel=%b pw=%b ew=%b m4=%b vec=%0d ven=%b cause=%0d busy=%b, expected sel=%b pw=%b ew=%b m4=%b vec=%0d ven=%b cause=%0d busy=%b",
             tag, got.pcSel, got.pcWrite, got.epcWrite, got.aluPcM4, got.vecAddr,
             got.vecAddrEn, got.cause, got.busy, want.pcSel, want.pcWrite,
             want.epcWrite, want.aluPcM4, want.vecAddr, want.vecAddrEn, want.cause,
             want.busy);
    end
    testsRun++;
    assert ((got.pcWrite & got.epcWrite) === 1'b0) else begin
      testsFailed++;
      $error("[TB] FAIL %s exclusive-writes: observed pw&ew=%b, expected 0",
             tag, got.pcWrite & got.epcWrite);
    end
  endtask

  // Predict the outputs that follow one clock edge, given the inputs it sampled.
  task automatic modelEdge(input logic f, input logic b, input logic t, input logic j,
                           input logic jr, input logic rte, input logic exc,
                           input logic [1:0] code);
    outs_t rec;
    logic  hit;
    logic [2:0] sel;
    if (expQ.size() != 0) begin
      expOut = expQ.pop_front();
    end else if (exc) begin
      lastCause        = (code == 2'd3) ? 2'd0 : code;
      lastVec          = VecBase + 8'(lastCause);
      expOut           = idleRecord();
      expOut.epcWrite  = 1'b1;
      expOut.aluPcM4   = 1'b1;
      expOut.busy      = 1'b1;
      for (int i = 0; i < MemWait; i++) begin
        rec           = idleRecord();
        rec.vecAddrEn = 1'b1;
        rec.busy      = 1'b1;
        expQ.push_back(rec);
      end
      lastSel     = 3'b000;
      rec         = idleRecord();
      rec.pcWrite = 1'b1;
      rec.busy    = 1'b1;
      expQ.push_back(rec);
      expQ.push_back(idleRecord());
    end else begin
      hit = 1'b1;
      sel = lastSel;
      if (rte)          sel = 3'b100;
      else if (jr)      sel = 3'b101;
      else if (j)       sel = 3'b011;
      else if (b && t)  sel = 3'b010;
      else if (f)       sel = 3'b001;
      else              hit = 1'b0;
      lastSel        = sel;
      expOut         = idleRecord();
      expOut.pcWrite = hit;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic f, input logic b,
                               input logic t, input logic j, input logic jr,
                               input logic rte, input logic exc, input logic [1:0] code);
    bus.fetch_req = f;
    bus.br_req    = b;
    bus.br_taken  = t;
    bus.j_req     = j;
    bus.jr_req    = jr;
    bus.rte_req   = rte;
    bus.exc_req   = exc;
    bus.exc_code  = code;
    @(posedge clk);
    #1;
    modelEdge(f, b, t, j, jr, rte, exc, code);
    checkOutput(tag, expOut);
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    zeroOut      = '0;
    lastSel      = 3'b000;
    lastCause    = 2'd0;
    lastVec      = 8'd0;
    bus.fetch_req = 1'b0;
    bus.br_req    = 1'b0;
    bus.br_taken  = 1'b0;
    bus.j_req     = 1'b0;
    bus.jr_req    = 1'b0;
    bus.rte_req   = 1'b0;
    bus.exc_req   = 1'b0;
    bus.exc_code  = 2'd0;

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset values", zeroOut);
    rst = 1'b0;
    idleCycles("idle after reset", 1);

    // One request at a time, each followed by an idle cycle
    applyStimulus("fetch", 1, 0, 0, 0, 0, 0, 0, 2'd0);
    idleCycles("fetch drop", 1);
    applyStimulus("jump", 0, 0, 0, 1, 0, 0, 0, 2'd0);
    idleCycles("jump drop", 1);
    applyStimulus("jr", 0, 0, 0, 0, 1, 0, 0, 2'd0);
    idleCycles("jr drop", 1);
    applyStimulus("rte", 0, 0, 0, 0, 0, 1, 0, 2'd0);
    idleCycles("rte drop", 1);
    applyStimulus("branch taken", 0, 1, 1, 0, 0, 0, 0, 2'd0);
    idleCycles("branch drop", 1);

    // Priority and the untaken branch
    applyStimulus("jr+j+fetch", 1, 0, 0, 1, 1, 0, 0, 2'd0);
    idleCycles("priority drop", 1);
    applyStimulus("branch untaken", 0, 1, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("exc over all", 1, 1, 1, 1, 1, 1, 1, 2'd2);
    idleCycles("exc over all seq", MemWait + 2);

    // Overflow exception walk-through
    applyStimulus("exc overflow", 0, 0, 0, 0, 0, 0, 1, 2'd1);
    idleCycles("overflow seq", MemWait + 3);

    // Remaining codes, with requests pulsed while busy
    applyStimulus("exc invalid", 0, 0, 0, 0, 0, 0, 1, 2'd0);
    applyStimulus("fetch while busy", 1, 0, 0, 0, 0, 0, 0, 2'd0);
    idleCycles("invalid seq", MemWait + 2);
    applyStimulus("exc divzero", 0, 0, 0, 0, 0, 0, 1, 2'd2);
    applyStimulus("idle in epc", 0, 0, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("exc while busy", 0, 0, 0, 0, 0, 0, 1, 2'd1);
    idleCycles("divzero seq", MemWait + 1);
    applyStimulus("exc reserved", 0, 0, 0, 0, 0, 0, 1, 2'd3);
    idleCycles("reserved seq", MemWait + 2);

    // Back-to-back: fetch in the first IDLE cycle after the PC load
    applyStimulus("fetch in first idle", 1, 0, 0, 0, 0, 0, 0, 2'd0);
    idleCycles("back-to-back drop", 1);

    // Reset in the middle of the memory wait
    applyStimulus("exc before reset", 0, 0, 0, 0, 0, 0, 1, 2'd2);
    idleCycles("into mem wait", 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset", zeroOut);
    expQ.delete();
    lastSel   = 3'b000;
    lastCause = 2'd0;
    lastVec   = 8'd0;
    @(posedge clk);
    #1;
    checkOutput("reset held", zeroOut);
    rst = 1'b0;
    idleCycles("idle after mid reset", 2);
    applyStimulus("fetch after reset", 1, 0, 0, 0, 0, 0, 0, 2'd0);

    // Random request traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus("random",
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)));
    end
    idleCycles("drain", MemWait + 3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
